ingress_port_stage: RTL

INGRESS_PORT_STAGE -- requirements
Module: ingress_port_stage

---
 rtl/ingress_port_stage_pkg.sv | 28 ++
 rtl/ingress_port_stage_sync_fifo.sv | 44 ++++
 rtl/ingress_port_stage.sv | 59 +++++
 3 files changed

// File: rtl/ingress_port_stage_pkg.sv
// ingress_port_stage_pkg: shared switch defaults plus sort-word width and field-offset helpers.
// Defaults come from `PORT_NUB_TOTAL and `DATA_WIDTH when they are not already defined elsewhere.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ingress_port_stage_pkg;
    localparam int DATA_OFF = 0;

    function automatic int width_port(input int pn, input int dw);
        return 1 + 2 * $clog2(pn) + dw;
    endfunction

    function automatic int src_off(input int pn, input int dw);
        return dw + 0 * pn;
    endfunction

    function automatic int dest_off(input int pn, input int dw);
        return dw + $clog2(pn);
    endfunction

    function automatic int valid_off(input int pn, input int dw);
        return dw + 2 * $clog2(pn);
    endfunction
endpackage

// File: rtl/ingress_port_stage_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ingress_port_stage.sv
// ingress_port_stage: buffers upstream words and frames one per slot strobe for the sort network.
// Optional INGRESS_STATS_EN adds a saturating issued_cnt output.
module ingress_port_stage
    import ingress_port_stage_pkg::*;
#(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [$clog2(PORT_NUB)-1:0]              in_dest,
    input  logic [DATA_WIDTH-1:0]                    in_data,
    input  logic                                     slot_en,
    output logic [width_port(PORT_NUB, DATA_WIDTH)-1:0] sort_word,
`ifdef INGRESS_STATS_EN
    output logic [15:0]                              issued_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]              fifo_cnt
);
    localparam int LG = $clog2(PORT_NUB);
    localparam int FW = LG + DATA_WIDTH;
    localparam logic [LG-1:0] SRC = LG'(PORT_ID);

    logic [FW-1:0] head;
    logic          full, empty, push, pop;

    // in_ready depends only on registered occupancy, so full blocks a push even alongside a pop.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = slot_en && !empty;

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_dest, in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) sort_word <= '0;
        else        sort_word <= pop ? {1'b1, head[FW-1 -: LG], SRC, head[DATA_WIDTH-1:0]} : '0;
    end

`ifdef INGRESS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                             issued_cnt <= '0;
        else if (pop && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
    end
`endif
endmodule
